serial_work_receive: RTL and testbench

Miner-side UART receiver for getwork loading. It samples the 8N1 serial line that the host-side transmitter drives and assembles bytes MSB-first into 32-bit words. It shifts the words into a 416-bit work register (target, nonce, data, midstate) and pulses `rx_done` when a complete job has arrived. It sits between the `RxD` pin and the blakeminer hashing core's work/nonce load logic.

---
 rtl/serial_work_receive.sv | 152 +++++++++++++++
 tb/tb_serial_work_receive.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_work_receive.sv
// serial_work_receive: 8N1 UART receiver assembling MSB-first 32-bit words into a multi-word work register.
module serial_work_receive #(
  parameter int comm_clk_frequency = 100_000_000,
  parameter int baud_rate          = 115_200,
  parameter int WORDS              = 13,
  parameter int GAP_BITS           = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RxD,
  output logic [32*WORDS-1:0]   data,
  output logic                  rx_done,
  output logic [31:0]           word,
  output logic                  word_valid,
  output logic                  frame_err,
  output logic                  busy
);
  localparam int CPB     = comm_clk_frequency / baud_rate;
  localparam int GAP_LIM = GAP_BITS * CPB;
  localparam int CW      = $clog2(CPB + 1);
  localparam int GW      = $clog2(GAP_LIM + 1);
  localparam int WW      = $clog2(WORDS + 1);
  localparam int DW      = 32 * WORDS;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     wreg_q, wreg_d;
  logic [31:0]     word_q, word_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [DW-1:0]   data_q, data_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            rx_done_q, rx_done_d;
  logic            word_valid_q, word_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            rxs, pend;

  assign rxs  = sync_q[1];
  assign pend = (bcnt_q != 2'd0) || (wcnt_q != '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    sh_d         = sh_q;
    bcnt_d       = bcnt_q;
    wreg_d       = wreg_q;
    word_d       = word_q;
    wcnt_d       = wcnt_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    rx_done_d    = 1'b0;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    gap_d        = (state_q == IDLE && rxs && pend) ? gap_q + 1'b1 : '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: if (cnt_q == CW'(CPB / 2 - 1)) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d = '0;
        sh_d  = {rxs, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d   = '0;
        state_d = IDLE;
        if (!rxs) begin
          frame_err_d = 1'b1;
          bcnt_d      = '0;
          wcnt_d      = '0;
        end else begin
          wreg_d = {wreg_q[15:0], sh_q};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            word_d       = {wreg_q, sh_q};
            word_valid_d = 1'b1;
            shreg_d      = {shreg_q[DW-33:0], word_d};
            wcnt_d       = (wcnt_q == WW'(WORDS - 1)) ? '0 : wcnt_q + 1'b1;
            if (wcnt_q == WW'(WORDS - 1)) begin
              data_d    = shreg_d;
              rx_done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // a stalled partial job is dropped silently; outputs keep their last values
    if (gap_q == GW'(GAP_LIM - 1)) begin
      bcnt_d = '0;
      wcnt_d = '0;
      gap_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      bcnt_q       <= '0;
      wreg_q       <= '0;
      word_q       <= '0;
      wcnt_q       <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      gap_q        <= '0;
      rx_done_q    <= 1'b0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], RxD};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      bcnt_q       <= bcnt_d;
      wreg_q       <= wreg_d;
      word_q       <= word_d;
      wcnt_q       <= wcnt_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      gap_q        <= gap_d;
      rx_done_q    <= rx_done_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data       = data_q;
  assign word       = word_q;
  assign rx_done    = rx_done_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_serial_work_receive.sv
// tb_serial_work_receive: drives 8N1 frames into serial_work_receive and checks words/jobs against a byte-level model.
module tb_serial_work_receive;
  localparam int CPB = 8;
  localparam int W   = 13;
  localparam int NB  = 4 * W;
  localparam int DW  = 32 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          RxD = 1'b1;
  logic [DW-1:0] data;
  logic          rx_done;
  logic [31:0]   word;
  logic          word_valid;
  logic          frame_err;
  logic          busy;

  serial_work_receive #(
    .comm_clk_frequency(1_000_000),
    .baud_rate(115_200),
    .WORDS(W),
    .GAP_BITS(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .RxD(RxD), .data(data), .rx_done(rx_done),
    .word(word), .word_valid(word_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  int          wv_cnt, rx_cnt, fe_cnt, busy_run, busy_max;
  logic [31:0] wq[$];
  logic [7:0]  vec[NB];
  logic [7:0]  cur[NB];

  always @(negedge clk) if (rst_n) begin
    if (word_valid) begin wv_cnt++; wq.push_back(word); end
    if (rx_done) rx_cnt++;
    if (frame_err) fe_cnt++;
    busy_run = busy ? busy_run + 1 : 0;
    if (busy_run > busy_max) busy_max = busy_run;
  end

  function automatic logic [DW-1:0] pack_job();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < NB; i++) r = {r[DW-9:0], cur[i]};
    return r;
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    return {cur[4*i], cur[4*i+1], cur[4*i+2], cur[4*i+3]};
  endfunction

  task automatic clear_mon();
    wv_cnt = 0; rx_cnt = 0; fe_cnt = 0; busy_run = 0; busy_max = 0;
    wq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    RxD = v;
    idle(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic send_cur();
    for (int i = 0; i < NB; i++) send_byte(cur[i], 1'b1);
    idle(20);
  endtask

  task automatic test_reset();
    idle(3);
    checks++; if (data !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", data); end
    checks++; if (word !== 32'h0) begin fails++; $display("FAIL reset_word: got %h expected 0", word); end
    checks++; if ({rx_done, word_valid, frame_err, busy} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {rx_done, word_valid, frame_err, busy}); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_single_word();
    logic [7:0] b[4] = '{8'h00, 8'h00, 8'h07, 8'hff};
    clear_mon();
    for (int i = 0; i < 4; i++) send_byte(b[i], 1'b1);
    idle(20);
    checks++; if (wv_cnt !== 1) begin fails++; $display("FAIL word_count: got %0d expected 1", wv_cnt); end
    checks++; if (word !== 32'h000007ff) begin fails++; $display("FAIL word_value: got %h expected 000007ff", word); end
    checks++; if (rx_cnt !== 0) begin fails++; $display("FAIL word_no_done: got %0d expected 0", rx_cnt); end
    checks++; if (data !== '0) begin fails++; $display("FAIL word_data_held: got %h expected 0", data); end
    idle(64 * CPB + 10);
  endtask

  task automatic test_job();
    cur = vec;
    clear_mon();
    send_cur();
    checks++; if (wv_cnt !== W) begin fails++; $display("FAIL job_words: got %0d expected %0d", wv_cnt, W); end
    checks++; if (rx_cnt !== 1) begin fails++; $display("FAIL job_done: got %0d expected 1", rx_cnt); end
    checks++; if (data !== pack_job()) begin fails++; $display("FAIL job_data: got %h expected %h", data, pack_job()); end
    for (int i = 0; i < W; i++) begin
      checks++;
      if (i >= wq.size() || wq[i] !== exp_word(i)) begin
        fails++; $display("FAIL job_word%0d: got %h expected %h", i, (i < wq.size()) ? wq[i] : 32'hx, exp_word(i));
      end
    end
    cur[7] = 8'h06;
    clear_mon();
    send_cur();
    checks++; if (rx_cnt !== 1) begin fails++; $display("FAIL job2_done: got %0d expected 1", rx_cnt); end
    checks++; if (data !== pack_job()) begin fails++; $display("FAIL job2_data: got %h expected %h", data, pack_job()); end
  endtask

  task automatic test_frame_err();
    cur = vec;
    clear_mon();
    send_byte(8'ha5, 1'b0);
    idle(2 * CPB);
    send_cur();
    checks++; if (fe_cnt !== 1) begin fails++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt); end
    checks++; if (rx_cnt !== 1) begin fails++; $display("FAIL ferr_done: got %0d expected 1", rx_cnt); end
    checks++; if (wv_cnt !== W) begin fails++; $display("FAIL ferr_words: got %0d expected %0d", wv_cnt, W); end
    checks++; if (data !== pack_job()) begin fails++; $display("FAIL ferr_data: got %h expected %h", data, pack_job()); end
  endtask

  task automatic test_glitch();
    cur = vec;
    cur[20] = 8'($urandom);
    clear_mon();
    RxD = 1'b0;
    idle(2);
    RxD = 1'b1;
    idle(20);
    checks++; if (busy_max > 4) begin fails++; $display("FAIL glitch_busy: got %0d expected <=4", busy_max); end
    checks++; if (wv_cnt + rx_cnt + fe_cnt !== 0) begin fails++; $display("FAIL glitch_pulses: got %0d expected 0", wv_cnt + rx_cnt + fe_cnt); end
    send_cur();
    checks++; if (rx_cnt !== 1) begin fails++; $display("FAIL glitch_done: got %0d expected 1", rx_cnt); end
    checks++; if (data !== pack_job()) begin fails++; $display("FAIL glitch_data: got %h expected %h", data, pack_job()); end
  endtask

  task automatic test_gap();
    cur = vec;
    cur[30] = 8'($urandom);
    clear_mon();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
    idle(64 * CPB + 10);
    send_cur();
    checks++; if (rx_cnt !== 1) begin fails++; $display("FAIL gap_done: got %0d expected 1", rx_cnt); end
    checks++; if (wv_cnt !== W + 1) begin fails++; $display("FAIL gap_words: got %0d expected %0d", wv_cnt, W + 1); end
    checks++; if (data !== pack_job()) begin fails++; $display("FAIL gap_data: got %h expected %h", data, pack_job()); end
  endtask

  task automatic test_async_reset();
    cur = vec;
    cur[40] = 8'($urandom);
    clear_mon();
    for (int i = 0; i < 19; i++) send_byte(cur[i], 1'b1);
    send_bit(1'b0);
    send_bit(cur[19][0]);
    send_bit(cur[19][1]);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (data !== '0) begin fails++; $display("FAIL areset_data: got %h expected 0", data); end
    checks++; if (word !== 32'h0) begin fails++; $display("FAIL areset_word: got %h expected 0", word); end
    checks++; if ({rx_done, word_valid, frame_err, busy} !== 4'b0) begin fails++; $display("FAIL areset_flags: got %b expected 0000", {rx_done, word_valid, frame_err, busy}); end
    checks++; if (rx_cnt !== 0) begin fails++; $display("FAIL areset_no_done: got %0d expected 0", rx_cnt); end
    RxD = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(4);
    clear_mon();
    send_cur();
    checks++; if (rx_cnt !== 1) begin fails++; $display("FAIL areset_done: got %0d expected 1", rx_cnt); end
    checks++; if (wv_cnt !== W) begin fails++; $display("FAIL areset_words: got %0d expected %0d", wv_cnt, W); end
    checks++; if (data !== pack_job()) begin fails++; $display("FAIL areset_data2: got %h expected %h", data, pack_job()); end
  endtask

  initial begin
    logic [7:0] head[12] = '{8'h00, 8'h00, 8'h07, 8'hff, 8'hff, 8'hbd, 8'h92, 8'h07, 8'hff, 8'hff, 8'h00, 8'h1e};
    logic [7:0] tail[4]  = '{8'hf0, 8'hea, 8'h63, 8'h3b};
    for (int i = 0; i < NB; i++) vec[i] = 8'($urandom);
    for (int i = 0; i < 12; i++) vec[i] = head[i];
    for (int i = 0; i < 4; i++) vec[NB-4+i] = tail[i];
    clear_mon();
    test_reset();
    test_single_word();
    test_job();
    test_frame_err();
    test_glitch();
    test_gap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
